// File: rtl/mux_channel_scanner.sv
// ---------------------------------------------------------------------------
// mux_channel_scanner
//
// Purpose:
//   Scans an upstream INS:1 single-bit mux. It walks the select s over the
//   channels and captures f_in for each one into data_out. When the whole
//   pass is done, it holds the word behind a valid/ready handshake.
//
// Build option (macro MASK_SKIP_EN):
//   undefined : every channel is visited, one cycle each. Masked channels
//               are written as 0. Latency is INS cycles.
//   defined   : only enabled channels are visited, in ascending order.
//               Latency is popcount(mask) cycles. An all-zero mask goes
//               straight from IDLE to HOLD with data_out = 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous, active-low reset
//   start      in   request one scan pass (only honoured in IDLE)
//   ch_mask    in   INS channel enables, sampled when start is accepted
//   s          out  SW-bit channel select to the upstream mux
//   f_in       in   mux output for the current s
//   data_out   out  captured word; bit k holds the channel-k sample
//   valid_out  out  data_out holds a complete scan
//   ready_in   in   downstream accepts data_out
//   busy       out  high in SCAN or HOLD
//   state_dbg  out  current FSM state (IDLE=0, SCAN=1, HOLD=2)
//
// Handshake (valid_out/ready_in):
//   A word transfers on a rising edge where valid_out and ready_in are both
//   high. While valid_out is high and ready_in is low, data_out and
//   valid_out do not change. valid_out never depends on ready_in.
// ---------------------------------------------------------------------------
module mux_channel_scanner #(
    parameter int INS = 8,
    parameter int SW  = $clog2(INS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [INS-1:0] ch_mask,
    output logic [SW-1:0]  s,
    input  logic           f_in,
    output logic [INS-1:0] data_out,
    output logic           valid_out,
    input  logic           ready_in,
    output logic           busy,
    output logic [1:0]     state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [SW-1:0]  s_nxt;
    logic [INS-1:0] data_nxt;
    logic [INS-1:0] mask_q, mask_nxt;

`ifdef MASK_SKIP_EN
    // Finds the lowest enabled channel at index >= lo.
    // Returns {found, index}.
    function automatic logic [SW:0] find_from(input logic [INS-1:0] m, input int lo);
        logic [SW:0] r;
        r = '0;
        for (int i = INS - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) begin
                r = {1'b1, SW'(i)};
            end
        end
        return r;
    endfunction

    logic [SW:0] first_ch;  // first enabled channel of the incoming mask
    logic [SW:0] next_ch;   // next enabled channel above s in the latched mask

    assign first_ch = find_from(ch_mask, 0);
    assign next_ch  = find_from(mask_q, int'(s) + 1);
`endif

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= '0;
            data_out <= '0;
            mask_q   <= '0;
        end else begin
            state    <= state_nxt;
            s        <= s_nxt;
            data_out <= data_nxt;
            mask_q   <= mask_nxt;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        data_nxt  = data_out;
        mask_nxt  = mask_q;

        case (state)
            IDLE: begin
                if (start) begin
                    mask_nxt = ch_mask;
                    data_nxt = '0;
`ifdef MASK_SKIP_EN
                    if (first_ch[SW]) begin
                        s_nxt     = first_ch[SW-1:0];
                        state_nxt = SCAN;
                    end else begin
                        // Nothing enabled: the empty word is ready at once.
                        s_nxt     = '0;
                        state_nxt = HOLD;
                    end
`else
                    s_nxt     = '0;
                    state_nxt = SCAN;
`endif
                end
            end

            SCAN: begin
                // Only bit s is written in this cycle.
                data_nxt[s] = f_in & mask_q[s];
`ifdef MASK_SKIP_EN
                if (next_ch[SW]) begin
                    s_nxt = next_ch[SW-1:0];
                end else begin
                    s_nxt     = '0;
                    state_nxt = HOLD;
                end
`else
                if (s == SW'(INS - 1)) begin
                    s_nxt     = '0;
                    state_nxt = HOLD;
                end else begin
                    s_nxt = s + SW'(1);
                end
`endif
            end

            HOLD: begin
                // A start in this cycle is ignored. The next start can only
                // be accepted from IDLE.
                if (ready_in) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                s_nxt     = '0;
            end
        endcase
    end

    assign valid_out = (state == HOLD);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// ---------------------------------------------------------------------------
// tb_mux_channel_scanner
//
// Self-checking bench for mux_channel_scanner with INS = 8.
// f_in is modelled as a bit of a word w selected by s.
//
// The expected behaviour comes from the rules of the block:
//   - the select visits each channel in the channel list once, in order
//     (all channels, or only the enabled ones when MASK_SKIP_EN is defined)
//   - the result word is w & mask
//   - latency, counted in edges after the accepting edge, is the length of
//     that channel list
// ---------------------------------------------------------------------------
module tb_mux_channel_scanner;
    localparam int INS = 8;
    localparam int SW  = 3;

    // Clock / reset block
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start    = 1'b0;
    logic           ready_in = 1'b0;
    logic [INS-1:0] ch_mask  = '0;
    logic [INS-1:0] w        = '0;
    logic [INS-1:0] data_out;
    logic [SW-1:0]  s;
    logic           f_in;
    logic           valid_out;
    logic           busy;
    logic [1:0]     state_dbg;

    assign f_in = w[s];

    mux_channel_scanner #(.INS(INS), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ch_mask   (ch_mask),
        .s         (s),
        .f_in      (f_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the ordered list of channels a pass visits
    function automatic bit visits(input logic [7:0] m, input int ch);
`ifdef MASK_SKIP_EN
        return m[ch];
`else
        return 1'b1;
`endif
    endfunction

    function automatic int exp_lat(input logic [7:0] m);
        int n = 0;
        for (int i = 0; i < INS; i++) if (visits(m, i)) n++;
        return n;
    endfunction

    typedef struct {
        logic [7:0] mask;
        logic [7:0] w;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[7];

    // Driver: present start with a mask and mux word on the falling edge
    task automatic launch(input logic [7:0] m, input logic [7:0] wv);
        @(negedge clk);
        ch_mask  = m;
        w        = wv;
        start    = 1'b1;
        ready_in = 1'b0;
    endtask

    // Scoreboard for one pass.
    // Call it while start is pending; the next rising edge must accept it.
    task automatic collect(input logic [7:0] m, input logic [7:0] wv,
                           input logic [7:0] exp_data, input int hold_cycles);
        int          lat;
        int          exp_s[$];
        int          got_s[$];
        logic [7:0]  part;
        logic [7:0]  word;
        int          n;

        @(posedge clk); #1;
        start   = 1'b0;
        ch_mask = ~m;  // must not affect the pass already accepted
        check("accept_busy", busy, 1);
        check("accept_clear", data_out, 0);

        for (int i = 0; i < INS; i++) if (visits(m, i)) exp_s.push_back(i);

        word = wv & m;
        part = '0;
        lat  = 0;
        while (!valid_out && lat < 64) begin
            got_s.push_back(int'(s));
            @(posedge clk); #1;
            lat++;
            part[got_s[got_s.size()-1]] = word[got_s[got_s.size()-1]];
            check("scan_partial", data_out, part);
        end

        check("latency", lat, exp_lat(m));
        check("s_seq_len", got_s.size(), exp_s.size());
        n = (got_s.size() < exp_s.size()) ? got_s.size() : exp_s.size();
        for (int i = 0; i < n; i++) check("s_seq", got_s[i], exp_s[i]);
        check("valid", valid_out, 1);
        check("data", data_out, exp_data);

        // Stall: toggle w and start; output must stay frozen
        repeat (hold_cycles) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            w     = INS'($urandom);
            @(posedge clk); #1;
            check("hold_valid", valid_out, 1);
            check("hold_busy", busy, 1);
            check("hold_data", data_out, exp_data);
            check("hold_s", s, 0);
        end

        // Handshake with a coinciding start that must be ignored
        @(negedge clk);
        ready_in = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        check("hs_busy", busy, 0);
        check("hs_valid", valid_out, 0);
        check("hs_s", s, 0);
        start    = 1'b0;
        ready_in = 1'b0;
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] wv;
        logic [7:0] bm[3];
        logic [7:0] bw[3];
        int         lat;
        int         n;
        int         seen;

        tbl[0] = '{mask: 8'hFF, w: 8'hA5, exp_data: 8'hA5};
        tbl[1] = '{mask: 8'h0F, w: 8'hFF, exp_data: 8'h0F};
        tbl[2] = '{mask: 8'h00, w: 8'hFF, exp_data: 8'h00};
        tbl[3] = '{mask: 8'h3C, w: 8'h5A, exp_data: 8'h18};
        tbl[4] = '{mask: 8'h81, w: 8'hFF, exp_data: 8'h81};
        tbl[5] = '{mask: 8'hAA, w: 8'h55, exp_data: 8'h00};
        tbl[6] = '{mask: 8'hF0, w: 8'hF0, exp_data: 8'hF0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s", s, 0);
        check("rst_data", data_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy, 0);

        // Start on the first edge after reset release, then a 5-cycle stall
        @(negedge clk);
        rst_n   = 1'b1;
        ch_mask = tbl[0].mask;
        w       = tbl[0].w;
        start   = 1'b1;
        collect(tbl[0].mask, tbl[0].w, tbl[0].exp_data, 5);

        // Table-driven vectors
        for (int i = 1; i < 7; i++) begin
            launch(tbl[i].mask, tbl[i].w);
            collect(tbl[i].mask, tbl[i].w, tbl[i].exp_data, $urandom_range(0, 2));
        end

        // Randomized passes against the model
        for (int i = 0; i < 20; i++) begin
            m  = 8'($urandom);
            wv = 8'($urandom);
            launch(m, wv);
            collect(m, wv, wv & m, $urandom_range(0, 2));
        end

        // Reset in the middle of a scan
        launch(8'hFF, 8'hC3);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (s != 3'd3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_rst_reach_s3", s, 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_s", s, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid_out || busy) seen++;
        end
        check("mid_rst_quiet", seen, 0);

        // Back-to-back passes with start held high and ready_in high
        bm[0] = 8'hC3; bw[0] = 8'h96;
        bm[1] = 8'h7E; bw[1] = 8'hFF;
        bm[2] = 8'h01; bw[2] = 8'h01;
        @(negedge clk);
        ch_mask  = bm[0];
        w        = bw[0];
        start    = 1'b1;
        ready_in = 1'b1;
        @(posedge clk); #1;
        for (int p = 0; p < 3; p++) begin
            check("b2b_busy", busy, 1);
            lat = 0;
            while (!valid_out && lat < 64) begin
                @(posedge clk); #1;
                lat++;
            end
            check("b2b_latency", lat, exp_lat(bm[p]));
            check("b2b_data", data_out, bw[p] & bm[p]);
            if (p < 2) begin
                ch_mask = bm[p+1];
                w       = bw[p+1];
            end
            @(posedge clk); #1;
            check("b2b_idle_gap", busy, 0);
            if (p < 2) begin
                @(posedge clk); #1;
            end
        end
        start    = 1'b0;
        ready_in = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
